stream_bfm: RTL and testbench
=============================

STREAM_BFM -- requirements
Module: stream_bfm

Interface
REQ-001 Parameter NUM_PACKETS, default 100: number of packets to send and to check.
REQ-002 Parameter START_LEN, default 60: byte length of the first packet.
REQ-003 Parameter MAX_LEN, default 1514: largest packet length; after it, length wraps to START_LEN.
REQ-004 Parameter SEED, default 32'hFFFF_FFFF: nonzero LFSR seed.
REQ-005 The block has one clock. Reset is asynchronous and active-low.
REQ-006 clk_i  in  1  clock for all logic.
REQ-007 rst_n_i  in  1  asynchronous active-low reset.
REQ-008 start_i  in  1  start pulse, sampled in IDLE.
REQ-009 tx_data_o  out  32  master data; byte0 is in [7:0] (little-endian).
REQ-010 tx_vldb_o  out  2  valid bytes minus 1; meaningful on the last beat only.
REQ-011 tx_valid_o  out  1  master beat valid.
REQ-012 tx_ready_i  in  1  sink ready.
REQ-013 tx_last_o  out  1  end of packet.
REQ-014 tx_user_o  out  1  tied 0.
REQ-015 rx_data_i  in  32  received data.
REQ-016 rx_vldb_i  in  2  received valid bytes minus 1.
REQ-017 rx_valid_i  in  1  received beat valid.
REQ-018 rx_last_i  in  1  received end of packet.
REQ-019 rx_user_i  in  1  received error flag.
REQ-020 rx_ready_o  out  1  tied 1.
REQ-021 rx_sop_o  out  1  next received beat is start of packet.
REQ-022 done_o  out  1  all NUM_PACKETS packets received.
REQ-023 pass_o  out  1  done_o and zero errors.
REQ-024 err_cnt_o  out  16  error count; saturates at 16'hFFFF.
REQ-025 rx_pkt_cnt_o  out  16  count of received packets.

Function
REQ-026 Master FSM has three states, IDLE, SEND and DONE: IDLE goes to SEND on start_i; SEND goes to DONE when the eop beat of packet NUM_PACKETS is accepted; DONE holds until reset.
REQ-027 A beat transfers on a clock edge with tx_valid_o=1 and tx_ready_i=1; while tx_valid_o=1 and tx_ready_i=0, all tx outputs hold stable.
REQ-028 Packet k (from 0) has length L = START_LEN+k, wrapping past MAX_LEN; it uses ceil(L/4) beats.
REQ-029 On the last beat, tx_last_o=1 and tx_vldb_o=(L-1) mod 4; invalid bytes are driven 0.
REQ-030 The next packet may start on the cycle after the eop transfer; no idle gap is required.
REQ-031 Payload source: a 32-bit Fibonacci LFSR, x^32+x^22+x^2+x+1, seeded with SEED; one step per transferred beat; data is the current LFSR state.
REQ-032 The checker holds its own copy of the LFSR and its own length sequence; each advances only on accepted rx beats (rx_valid_i=1).
REQ-033 Each rx beat is checked against the expected data on valid bytes only; any mismatch adds 1 to err_cnt_o.
REQ-034 The following also add 1 each to err_cnt_o: rx_last_i arriving at the wrong beat index; rx_vldb_i wrong on eop; rx_user_i=1 on eop.
REQ-035 When rx_last_i comes early, the checker resyncs to the next expected packet; when an expected eop is missing, the checker counts 1 error and treats the beat as that packet's eop.
REQ-036 rx_sop_o is set after reset and on an eop beat, and cleared on a non-eop valid beat.
REQ-037 rx_pkt_cnt_o increments on each rx eop beat.
REQ-038 done_o sets when rx_pkt_cnt_o equals NUM_PACKETS and then stays set; beats arriving after done_o are ignored.
REQ-039 When a tx transfer and an rx beat occur in the same cycle, both are handled independently.

Reset
REQ-040 Reset values: FSM=IDLE, tx_valid_o=0, tx_last_o=0, tx_data_o=0, tx_vldb_o=0, LFSRs=SEED, rx_sop_o=1, done_o=0, pass_o=0, err_cnt_o=0, rx_pkt_cnt_o=0.
REQ-041 Reset mid-packet aborts all activity at once; a new start_i is needed after reset.

Verification
REQ-042 tx looped to rx, ready=1, start_i pulse -> 100 packets of 60..159 bytes; done_o=1, err_cnt_o=0, pass_o=1.
REQ-043 First packet (60 B) -> 15 beats, eop beat with tx_vldb_o=3; second packet (61 B) -> 16 beats, eop beat with tx_vldb_o=0 and data[31:8]=0.
REQ-044 tx_ready_i toggled pseudo-randomly at 50%, in loopback -> tx outputs stable while stalled; pass_o=1.
REQ-045 One data bit inverted in the loopback path on one beat -> err_cnt_o=1, pass_o=0 at done.
REQ-046 rx_user_i forced to 1 on one eop -> err_cnt_o=1; rx_pkt_cnt_o still reaches 100.
REQ-047 rst_n_i pulsed low in the middle of packet 5 -> all outputs take reset values at once, rx_sop_o=1; a restart then passes.

Source files
------------

// File: rtl/stream_bfm.sv
// Self-contained stream traffic generator plus checker: an LFSR-payload packet
// master on the tx side and a matching in-order checker on the rx side.
module stream_bfm #(
  parameter int          NUM_PACKETS = 100,
  parameter int          START_LEN   = 60,
  parameter int          MAX_LEN     = 1514,
  parameter logic [31:0] SEED        = 32'hFFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        start_i,
  output logic [31:0] tx_data_o,
  output logic [1:0]  tx_vldb_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        tx_last_o,
  output logic        tx_user_o,
  input  logic [31:0] rx_data_i,
  input  logic [1:0]  rx_vldb_i,
  input  logic        rx_valid_i,
  input  logic        rx_last_i,
  input  logic        rx_user_i,
  output logic        rx_ready_o,
  output logic        rx_sop_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_cnt_o,
  output logic [15:0] rx_pkt_cnt_o
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [31:0] byte_mask(input logic [1:0] vldb);
    logic [31:0] m;
    case (vldb)
      2'd0:    m = 32'h0000_00FF;
      2'd1:    m = 32'h0000_FFFF;
      2'd2:    m = 32'h00FF_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  function automatic logic [15:0] next_len(input logic [15:0] l);
    return (l >= 16'(MAX_LEN)) ? 16'(START_LEN) : l + 16'd1;
  endfunction

  // ---------------- master ----------------
  state_t      state_q, state_d;
  logic [31:0] tx_lfsr_q;
  logic [15:0] tx_len_q;
  logic [15:0] tx_beat_q;
  logic [15:0] tx_pkt_q;
  logic [15:0] tx_len_m1;
  logic        tx_last_beat;
  logic        tx_fire;

  assign tx_len_m1    = tx_len_q - 16'd1;
  assign tx_last_beat = (tx_beat_q == {2'b00, tx_len_m1[15:2]});
  assign tx_fire      = (state_q == SEND) && tx_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = SEND;
      SEND: if (tx_fire && tx_last_beat && (tx_pkt_q == 16'(NUM_PACKETS - 1)))
              state_d = DONE;
      default: state_d = DONE;
    endcase
  end

  always_comb begin
    tx_valid_o = (state_q == SEND);
    tx_last_o  = tx_valid_o && tx_last_beat;
    tx_vldb_o  = tx_last_o ? tx_len_m1[1:0] : 2'd0;
    tx_data_o  = 32'd0;
    if (tx_valid_o)
      tx_data_o = tx_last_beat ? (tx_lfsr_q & byte_mask(tx_len_m1[1:0])) : tx_lfsr_q;
  end

  // Payload/length bookkeeping only moves on an accepted beat, so a stall
  // keeps every tx output frozen for free.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_lfsr_q <= SEED;
      tx_len_q  <= 16'(START_LEN);
      tx_beat_q <= 16'd0;
      tx_pkt_q  <= 16'd0;
    end else if (tx_fire) begin
      tx_lfsr_q <= lfsr_step(tx_lfsr_q);
      if (tx_last_beat) begin
        tx_beat_q <= 16'd0;
        tx_len_q  <= next_len(tx_len_q);
        tx_pkt_q  <= tx_pkt_q + 16'd1;
      end else begin
        tx_beat_q <= tx_beat_q + 16'd1;
      end
    end
  end

  assign tx_user_o = 1'b0;

  // ---------------- checker ----------------
  logic [31:0] rx_lfsr_q;
  logic [15:0] rx_len_q;
  logic [15:0] rx_beat_q;
  logic        rx_sop_q;
  logic        done_q;
  logic [15:0] err_q;
  logic [15:0] cnt_q;
  logic [15:0] rx_len_m1;
  logic        exp_last;
  logic        rx_acc;
  logic        data_err, idx_err, vldb_err, user_err;
  logic [2:0]  err_inc;
  logic [16:0] err_sum;
  logic [15:0] err_next;

  assign rx_len_m1 = rx_len_q - 16'd1;
  assign exp_last  = (rx_beat_q == {2'b00, rx_len_m1[15:2]});
  assign rx_acc    = rx_valid_i && !done_q;

  always_comb begin
    data_err = |((rx_data_i ^ rx_lfsr_q) &
                 (exp_last ? byte_mask(rx_len_m1[1:0]) : 32'hFFFF_FFFF));
    idx_err  = (rx_last_i != exp_last);
    vldb_err = rx_last_i && exp_last && (rx_vldb_i != rx_len_m1[1:0]);
    user_err = rx_last_i && rx_user_i;
    err_inc  = {2'b00, data_err} + {2'b00, idx_err} + {2'b00, vldb_err} + {2'b00, user_err};
    err_sum  = {1'b0, err_q} + {14'd0, err_inc};
    err_next = err_sum[16] ? 16'hFFFF : err_sum[15:0];
  end

  // An early rx eop and a missing expected eop both close the expected packet,
  // so the checker always realigns on the next packet boundary.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_lfsr_q <= SEED;
      rx_len_q  <= 16'(START_LEN);
      rx_beat_q <= 16'd0;
      rx_sop_q  <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 16'd0;
      cnt_q     <= 16'd0;
    end else if (rx_acc) begin
      rx_lfsr_q <= lfsr_step(rx_lfsr_q);
      err_q     <= err_next;
      if (rx_last_i || exp_last) begin
        rx_beat_q <= 16'd0;
        rx_len_q  <= next_len(rx_len_q);
      end else begin
        rx_beat_q <= rx_beat_q + 16'd1;
      end
      if (rx_last_i) begin
        rx_sop_q <= 1'b1;
        cnt_q    <= cnt_q + 16'd1;
        if (cnt_q + 16'd1 == 16'(NUM_PACKETS)) done_q <= 1'b1;
      end else begin
        rx_sop_q <= 1'b0;
      end
    end
  end

  assign rx_ready_o   = 1'b1;
  assign rx_sop_o     = rx_sop_q;
  assign done_o       = done_q;
  assign pass_o       = done_q && (err_q == 16'd0);
  assign err_cnt_o    = err_q;
  assign rx_pkt_cnt_o = cnt_q;

endmodule

// File: tb/tb_stream_bfm.sv
// Loopback bench for stream_bfm: tx beats are compared against a packet-level
// model of the expected stream; rx side is exercised with injected faults.
module tb_stream_bfm;
  localparam int          NP = 100;
  localparam int          SL = 60;
  localparam int          ML = 1514;
  localparam logic [31:0] SD = 32'hFFFF_FFFF;

  logic        clk, rst_n, start, tx_ready;
  logic [31:0] tx_data, rx_data;
  logic [1:0]  tx_vldb, rx_vldb;
  logic        tx_valid, tx_last, tx_user;
  logic        rx_valid, rx_last, rx_user, rx_ready, rx_sop;
  logic        done, pass;
  logic [15:0] err_cnt, rx_pkt_cnt;

  logic        flip_en, user_en, rand_ready;
  int          flip_at, user_pkt;
  int          xfer_idx, pkt_idx;

  stream_bfm #(.NUM_PACKETS(NP), .START_LEN(SL), .MAX_LEN(ML), .SEED(SD)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .tx_data_o(tx_data), .tx_vldb_o(tx_vldb), .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready), .tx_last_o(tx_last), .tx_user_o(tx_user),
    .rx_data_i(rx_data), .rx_vldb_i(rx_vldb), .rx_valid_i(rx_valid),
    .rx_last_i(rx_last), .rx_user_i(rx_user), .rx_ready_o(rx_ready),
    .rx_sop_o(rx_sop), .done_o(done), .pass_o(pass),
    .err_cnt_o(err_cnt), .rx_pkt_cnt_o(rx_pkt_cnt)
  );

  // Loopback path with optional single-bit and error-flag injection.
  assign rx_valid = tx_valid & tx_ready;
  assign rx_last  = tx_last;
  assign rx_vldb  = tx_vldb;
  assign rx_data  = tx_data ^ {31'd0, (flip_en && xfer_idx == flip_at)};
  assign rx_user  = user_en && (pkt_idx == user_pkt) && tx_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_idx <= 0;
      pkt_idx  <= 0;
    end else if (tx_valid && tx_ready) begin
      xfer_idx <= xfer_idx + 1;
      if (tx_last) pkt_idx <= pkt_idx + 1;
    end
  end

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [1:0]  vldb;
  } beat_t;
  beat_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & 32'h8020_0003)};
  endfunction

  // Expected tx stream straight from the packet rules: lengths, beat counts,
  // one LFSR value per beat, unused tail bytes zeroed.
  task automatic build_model();
    int          len = SL;
    logic [31:0] s = SD;
    for (int k = 0; k < NP; k++) begin
      int nb = (len + 3) / 4;
      for (int b = 0; b < nb; b++) begin
        beat_t t;
        int    nbytes = (b == nb - 1) ? len - 4 * b : 4;
        t.data = s;
        for (int y = nbytes; y < 4; y++) t.data[8*y +: 8] = 8'h00;
        t.last = (b == nb - 1);
        t.vldb = t.last ? 2'(nbytes - 1) : 2'd0;
        exp_q.push_back(t);
        s = lfsr_next(s);
      end
      len = (len == ML) ? SL : len + 1;
    end
  endtask

  int          cmp_idx, cur_beats, pkt_no, exp_cnt;
  logic        stalled, exp_sop;
  logic [34:0] hold;
  int          pkt_beats[2];
  logic [31:0] pkt_ldata[2];
  logic [1:0]  pkt_lvldb[2];

  task automatic compare_step();
    if (!rst_n) begin
      cmp_idx = 0; cur_beats = 0; pkt_no = 0; exp_cnt = 0;
      stalled = 1'b0; exp_sop = 1'b1;
      return;
    end
    chk("rx_sop", 64'(rx_sop), 64'(exp_sop));
    chk("rx_pkt_cnt", 64'(rx_pkt_cnt), 64'(exp_cnt));
    if (stalled)
      chk("stall_hold", {28'd0, tx_valid, tx_data, tx_last, tx_vldb}, {28'd0, 1'b1, hold});
    stalled = 1'b0;
    if (tx_valid) begin
      if (tx_ready) begin
        if (cmp_idx < exp_q.size())
          chk("tx_beat", {29'd0, tx_data, tx_last, tx_vldb, tx_user},
              {29'd0, exp_q[cmp_idx].data, exp_q[cmp_idx].last, exp_q[cmp_idx].vldb, 1'b0});
        else
          chk("tx_extra_beat", 64'(cmp_idx), 64'(exp_q.size()));
        cmp_idx++;
        cur_beats++;
        exp_sop = tx_last;
        if (tx_last) begin
          if (pkt_no < 2) begin
            pkt_beats[pkt_no] = cur_beats;
            pkt_ldata[pkt_no] = tx_data;
            pkt_lvldb[pkt_no] = tx_vldb;
          end
          pkt_no++;
          exp_cnt++;
          cur_beats = 0;
        end
      end else begin
        stalled = 1'b1;
        hold = {tx_data, tx_last, tx_vldb};
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_tx"}, {28'd0, tx_valid, tx_last, tx_vldb, tx_data}, 64'd0);
    chk({tag, "_rx_flags"}, {61'd0, rx_sop, done, pass}, 64'b100);
    chk({tag, "_counts"}, {32'd0, err_cnt, rx_pkt_cnt}, 64'd0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20000) begin
      @(posedge clk);
      n++;
    end
    #1 chk({tag, "_done"}, 64'(done), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic expect_end(input string tag, input int errs);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(errs));
    chk({tag, "_pass"}, 64'(pass), 64'(errs == 0));
    chk({tag, "_pkt_cnt"}, 64'(rx_pkt_cnt), 64'(NP));
    chk({tag, "_beats_seen"}, 64'(cmp_idx), 64'(exp_q.size()));
    chk({tag, "_tx_idle"}, 64'(tx_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1; rand_ready = 1'b0;
    flip_en = 1'b0; user_en = 1'b0; flip_at = 0; user_pkt = 0;

    build_model();
    chk("model_size", 64'(exp_q.size()), 64'd2775);
    chk("model_beat0", 64'(exp_q[0].data), 64'hFFFF_FFFF);
    chk("model_beat1", 64'(exp_q[1].data), 64'hFFFF_FFFE);
    chk("model_pkt0_eop", {61'd0, exp_q[14].last, exp_q[14].vldb}, 64'b111);

    fork
      forever begin
        @(negedge clk);
        compare_step();
      end
      forever begin
        @(posedge clk);
        #1 tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    join_none

    // Plain loopback, always ready.
    do_reset();
    check_reset_vals("reset");
    repeat (5) @(posedge clk);
    #1 chk("no_start_idle", 64'(tx_valid), 64'd0);
    pulse_start();
    wait_done("basic");
    expect_end("basic", 0);
    chk("pkt0_beats", 64'(pkt_beats[0]), 64'd15);
    chk("pkt0_vldb", 64'(pkt_lvldb[0]), 64'd3);
    chk("pkt1_beats", 64'(pkt_beats[1]), 64'd16);
    chk("pkt1_vldb", 64'(pkt_lvldb[1]), 64'd0);
    chk("pkt1_tail_zero", 64'(pkt_ldata[1][31:8]), 64'd0);

    // Random backpressure.
    rand_ready = 1'b1;
    do_reset();
    pulse_start();
    wait_done("stall");
    expect_end("stall", 0);

    // Single inverted data bit mid-packet.
    do_reset();
    flip_en = 1'b1; flip_at = 100;
    pulse_start();
    wait_done("bitflip");
    expect_end("bitflip", 1);
    flip_en = 1'b0;

    // Error flag raised on one eop.
    do_reset();
    user_en = 1'b1; user_pkt = 7;
    pulse_start();
    wait_done("user");
    expect_end("user", 1);
    user_en = 1'b0;

    // Reset in the middle of packet 5, then a clean restart.
    do_reset();
    pulse_start();
    begin
      int n = 0;
      while (pkt_idx < 5 && n < 5000) begin
        @(posedge clk);
        n++;
      end
      chk("reach_pkt5", 64'(pkt_idx), 64'd5);
    end
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("midreset_no_restart", 64'(tx_valid), 64'd0);
    pulse_start();
    wait_done("restart");
    expect_end("restart", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
